car_sprite_mover: RTL and testbench
===================================

Name: car_sprite_mover

Overview:
- Player-controlled car sprite for the 1280x800 tile-based board game display.
- Holds the car position and moves it once per video frame from four push-button inputs.
- Blocks any move that would put the car on grass or off screen, using the 40x25 background tilemap.
- Overlays the car onto the incoming background pixel. Sits between the background renderer and the VGA output stage.

Parameters:
- TILE_SIZE, 32, tile edge in pixels (40x25 tiles = 1280x800).
- CAR_W, 32, car width in pixels.
- CAR_H, 32, car height in pixels.
- STEP, 2, pixels moved per frame while a direction is held.
- START_X, 640, reset x position (top-left corner of car).
- START_Y, 192, reset y position (top-left corner of car).
- CAR_COLOR, 12'h0F0, car body colour as {r,g,b}.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-high.
- curr_x  in  11  current scan x; visible range 0..1279.
- curr_y  in  10  current scan y; visible range 0..799.
- bg_color  in  12  background pixel {r[3:0],g[3:0],b[3:0]} for (curr_x,curr_y).
- in_up  in  1  move-up button, asynchronous, active-high.
- in_down  in  1  move-down button, asynchronous, active-high.
- in_left  in  1  move-left button, asynchronous, active-high.
- in_right  in  1  move-right button, asynchronous, active-high.
- tilemap  in  25x40x5  tile codes indexed [row][col]; code 0 = grass (blocked), 1..21 = road (drivable).
- o_pix_r  out  4  output pixel red.
- o_pix_g  out  4  output pixel green.
- o_pix_b  out  4  output pixel blue.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- On rst: car_x=START_X, car_y=START_Y; button synchronizers cleared.
- Buttons: each passes through a 2-flop synchronizer on clk before use.
- Frame tick: asserted for exactly one cycle when curr_x==0 && curr_y==0. Position updates only on that cycle.
- Direction priority (one axis per frame): up > down > left > right. No button held -> no move.
- Candidate position: current position ±STEP on the chosen axis, computed in signed 12-bit arithmetic.
- Reject the candidate if:
  - x<0, x>1280-CAR_W, y<0, or y>800-CAR_H; or
  - the tile under any of the four corners (x,y), (x+CAR_W-1,y), (x,y+CAR_H-1), (x+CAR_W-1,y+CAR_H-1) is code 0.
- Tile index for a corner: col = px>>5, row = py>>5.
- Rejected candidate: position holds; no partial step is taken.
- Pixel path is combinational (zero latency): if car_x <= curr_x < car_x+CAR_W and car_y <= curr_y < car_y+CAR_H, output CAR_COLOR; otherwise output bg_color unchanged.
- Outside the visible area the pixel is still muxed normally; blanking is handled downstream.
- Reset mid-frame: position snaps to the start values immediately; the next frame tick proceeds normally.
- tilemap is treated as static; combinational reads only.

Decomposition:
- Shared package game_pkg:
  - SCREEN_W=1280, SCREEN_H=800, TILE_SIZE=32, MAP_COLS=40, MAP_ROWS=25.
  - TILE_GRASS=0.
  - typedef tile_t (logic [4:0]).
  - typedef rgb12_t.
- One sub-module, car_path_checker: takes the candidate (x,y) and tilemap, returns a drivable flag. It performs the four corner tile lookups plus the bounds check.

Test Plan:
- Reset: assert rst, release, scan a frame -> pixel (650,200) = 0F0; pixel (0,0) = bg_color passthrough; position (640,192).
- Move right: hold in_right for 3 frame ticks -> car_x=646, car_y=192; pixel (676,200) now car colour.
- Up into grass: hold in_up from reset -> y decreases 2/frame to 160 (row 5, code 1), then stays 160 (row 4 is grass).
- Left into grass: hold in_left at y=192 -> x decreases to 320 (col 10), then holds (col 9 is grass).
- Simultaneous buttons: in_up+in_down+in_right for 1 tick -> y=190, x unchanged.
- Reset mid-move: after 10 ticks of in_right, pulse rst mid-line -> position back to (640,192) immediately; next tick moves from there.

Source files
------------

// File: rtl/game_pkg.sv
// Shared board geometry, tile codes and pixel types for the tile-based game display.
package game_pkg;

  localparam int SCREEN_W  = 1280;
  localparam int SCREEN_H  = 800;
  localparam int TILE_SIZE = 32;
  localparam int MAP_COLS  = 40;
  localparam int MAP_ROWS  = 25;

  typedef logic [4:0] tile_t;

  localparam tile_t TILE_GRASS = 5'd0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef tile_t [MAP_ROWS-1:0][MAP_COLS-1:0] tilemap_t;

endpackage

// File: rtl/car_path_checker.sv
// Decides whether a candidate car position is on screen with all four corners on road tiles.
// Purely combinational; the candidate is judged in the same cycle it is presented.
module car_path_checker
  import game_pkg::*;
#(
  parameter int TILE_SIZE = 32,
  parameter int CAR_W     = 32,
  parameter int CAR_H     = 32
) (
  input  logic signed [11:0] cand_x,
  input  logic signed [11:0] cand_y,
  input  tilemap_t           tilemap,
  output logic               drivable
);

  localparam int                 SHIFT = $clog2(TILE_SIZE);
  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - CAR_W);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - CAR_H);

  logic        in_bounds;
  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic [5:0]  c0, c1;
  logic [4:0]  r0, r1;

  always_comb begin
    in_bounds = (cand_x >= 12'sd0) && (cand_x <= MAX_X) &&
                (cand_y >= 12'sd0) && (cand_y <= MAX_Y);
    // Park the lookups on tile (0,0) when off screen so indices never leave the map.
    x0 = in_bounds ? cand_x[10:0] : '0;
    y0 = in_bounds ? cand_y[9:0]  : '0;
    x1 = x0 + 11'(CAR_W - 1);
    y1 = y0 + 10'(CAR_H - 1);
    c0 = 6'(x0 >> SHIFT);
    c1 = 6'(x1 >> SHIFT);
    r0 = 5'(y0 >> SHIFT);
    r1 = 5'(y1 >> SHIFT);
    drivable = in_bounds &&
               (tilemap[r0][c0] != TILE_GRASS) &&
               (tilemap[r0][c1] != TILE_GRASS) &&
               (tilemap[r1][c0] != TILE_GRASS) &&
               (tilemap[r1][c1] != TILE_GRASS);
  end

endmodule

// File: rtl/car_sprite_mover.sv
// Player car: button-driven position update once per frame, blocked by grass and screen edges.
// Pixel overlay is combinational (zero latency); buttons see two cycles of synchroniser delay.
module car_sprite_mover
  import game_pkg::*;
#(
  parameter int          TILE_SIZE = 32,
  parameter int          CAR_W     = 32,
  parameter int          CAR_H     = 32,
  parameter int          STEP      = 2,
  parameter int          START_X   = 640,
  parameter int          START_Y   = 192,
  parameter logic [11:0] CAR_COLOR = 12'h0F0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] curr_x,
  input  logic [9:0]  curr_y,
  input  logic [11:0] bg_color,
  input  logic        in_up,
  input  logic        in_down,
  input  logic        in_left,
  input  logic        in_right,
  input  tilemap_t    tilemap,
  output logic [3:0]  o_pix_r,
  output logic [3:0]  o_pix_g,
  output logic [3:0]  o_pix_b
);

  localparam logic signed [11:0] STEP_S = 12'(STEP);

  // Button vectors are ordered {right, left, down, up}.
  logic [3:0]        btn_meta;
  logic [3:0]        btn_sync;
  logic [11:0]       car_x, car_y;
  logic signed [11:0] cand_x, cand_y;
  logic              move_req;
  logic              drivable;
  logic              frame_tick;
  logic              in_car;
  logic [11:0]       scan_x, scan_y;
  rgb12_t            pix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {in_right, in_left, in_down, in_up};
      btn_sync <= btn_meta;
    end
  end

  assign frame_tick = (curr_x == '0) && (curr_y == '0);

  // Only one axis moves per frame; the highest-priority held button wins.
  always_comb begin
    cand_x   = $signed(car_x);
    cand_y   = $signed(car_y);
    move_req = 1'b1;
    if (btn_sync[0])      cand_y = $signed(car_y) - STEP_S;
    else if (btn_sync[1]) cand_y = $signed(car_y) + STEP_S;
    else if (btn_sync[2]) cand_x = $signed(car_x) - STEP_S;
    else if (btn_sync[3]) cand_x = $signed(car_x) + STEP_S;
    else                  move_req = 1'b0;
  end

  car_path_checker #(
    .TILE_SIZE (TILE_SIZE),
    .CAR_W     (CAR_W),
    .CAR_H     (CAR_H)
  ) u_path_checker (
    .cand_x   (cand_x),
    .cand_y   (cand_y),
    .tilemap  (tilemap),
    .drivable (drivable)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car_x <= 12'(START_X);
      car_y <= 12'(START_Y);
    end else if (frame_tick && move_req && drivable) begin
      car_x <= cand_x;
      car_y <= cand_y;
    end
  end

  always_comb begin
    scan_x = {1'b0, curr_x};
    scan_y = {2'b0, curr_y};
    in_car = (scan_x >= car_x) && (scan_x < car_x + 12'(CAR_W)) &&
             (scan_y >= car_y) && (scan_y < car_y + 12'(CAR_H));
    pix    = in_car ? rgb12_t'(CAR_COLOR) : rgb12_t'(bg_color);
  end

  assign o_pix_r = pix.r;
  assign o_pix_g = pix.g;
  assign o_pix_b = pix.b;

endmodule

// File: tb/tb_car_sprite_mover.sv
// Randomised bench for car_sprite_mover against a frame-level position model.
module tb_car_sprite_mover;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] curr_x;
  logic [9:0]  curr_y;
  logic [11:0] bg_color;
  logic        in_up, in_down, in_left, in_right;
  tilemap_t    tilemap;
  logic [3:0]  o_pix_r, o_pix_g, o_pix_b;

  int n_tests = 0;
  int n_fail  = 0;
  int mx, my;
  int map_m [MAP_ROWS][MAP_COLS];

  localparam logic [3:0] B_UP = 4'b0001, B_DN = 4'b0010, B_LT = 4'b0100, B_RT = 4'b1000;

  car_sprite_mover dut (
    .clk      (clk),
    .rst      (rst),
    .curr_x   (curr_x),
    .curr_y   (curr_y),
    .bg_color (bg_color),
    .in_up    (in_up),
    .in_down  (in_down),
    .in_left  (in_left),
    .in_right (in_right),
    .tilemap  (tilemap),
    .o_pix_r  (o_pix_r),
    .o_pix_g  (o_pix_g),
    .o_pix_b  (o_pix_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int r, input int c, input int code);
    map_m[r][c]   = code;
    tilemap[r][c] = 5'(code);
  endtask

  function automatic bit ref_ok(input int x, input int y);
    if (x < 0 || y < 0 || x > SCREEN_W - 32 || y > SCREEN_H - 32) return 1'b0;
    return map_m[y/32][x/32] != 0 && map_m[y/32][(x+31)/32] != 0 &&
           map_m[(y+31)/32][x/32] != 0 && map_m[(y+31)/32][(x+31)/32] != 0;
  endfunction

  task automatic model_step(input logic [3:0] b);
    int cx = mx, cy = my;
    if (b[0])      cy -= 2;
    else if (b[1]) cy += 2;
    else if (b[2]) cx -= 2;
    else if (b[3]) cx += 2;
    else return;
    if (ref_ok(cx, cy)) begin
      mx = cx;
      my = cy;
    end
  endtask

  function automatic logic [11:0] rand_bg();
    logic [11:0] bg = 12'($urandom_range(0, 4095));
    return (bg == 12'h0F0) ? 12'h123 : bg;
  endfunction

  // Probe one pixel; expectation comes from the model position.
  task automatic probe(input string tag, input int px, input int py);
    int qx = px & 2047;
    int qy = py & 1023;
    logic [11:0] bg = rand_bg();
    logic [11:0] exp;
    @(negedge clk);
    curr_x = 11'(qx); curr_y = 10'(qy); bg_color = bg;
    #1;
    exp = (qx >= mx && qx < mx + 32 && qy >= my && qy < my + 32) ? 12'h0F0 : bg;
    chk(tag, {o_pix_r, o_pix_g, o_pix_b}, exp);
  endtask

  // Probe one pixel against a fixed expectation (car colour or passthrough).
  task automatic probe_exp(input string tag, input int px, input int py, input bit car);
    logic [11:0] bg = rand_bg();
    @(negedge clk);
    curr_x = 11'(px); curr_y = 10'(py); bg_color = bg;
    #1;
    chk(tag, {o_pix_r, o_pix_g, o_pix_b}, car ? 12'h0F0 : bg);
  endtask

  task automatic probe_box(input string tag);
    probe({tag, "_tl"}, mx, my);
    probe({tag, "_br"}, mx + 31, my + 31);
    probe({tag, "_l"},  mx - 1, my);
    probe({tag, "_r"},  mx + 32, my);
    probe({tag, "_u"},  mx, my - 1);
    probe({tag, "_d"},  mx, my + 32);
  endtask

  task automatic do_ticks(input logic [3:0] b, input int n);
    @(negedge clk);
    curr_x = 11'd5; curr_y = 10'd5;
    {in_right, in_left, in_down, in_up} = b;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      curr_x = '0; curr_y = '0;
      @(negedge clk);
      model_step(b);
      curr_x = 11'd5; curr_y = 10'd5;
      @(negedge clk);
    end
    {in_right, in_left, in_down, in_up} = 4'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {in_right, in_left, in_down, in_up} = 4'b0;
    curr_x = 11'd5; curr_y = 10'd5;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mx = 640; my = 192;
  endtask

  initial begin
    rst = 1'b1;
    curr_x = 11'd5; curr_y = 10'd5; bg_color = 12'h000;
    {in_right, in_left, in_down, in_up} = 4'b0;
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        set_tile(r, c, (r >= 5 && r <= 15 && c >= 10 && c <= 35) ? $urandom_range(1, 21) : 0);
    mx = 640; my = 192;
    repeat (3) @(negedge clk);
    probe_exp("in_reset", 650, 200, 1'b1);
    rst = 1'b0;

    probe_exp("rst_650_200", 650, 200, 1'b1);
    probe_exp("rst_0_0", 0, 0, 1'b0);
    probe_exp("rst_tl", 640, 192, 1'b1);
    probe_exp("rst_left", 639, 192, 1'b0);
    probe_exp("rst_above", 640, 191, 1'b0);
    probe_exp("rst_br", 671, 223, 1'b1);
    probe_exp("rst_right", 672, 223, 1'b0);

    do_ticks(B_RT, 3);
    probe_exp("rt3_676", 676, 200, 1'b1);
    probe_exp("rt3_677", 677, 200, 1'b1);
    probe_exp("rt3_678", 678, 200, 1'b0);
    probe_exp("rt3_645", 645, 200, 1'b0);
    probe_box("rt3");

    do_reset();
    do_ticks(B_UP, 30);
    probe_exp("up_top", 650, 160, 1'b1);
    probe_exp("up_above", 650, 159, 1'b0);
    probe_exp("up_bot", 650, 191, 1'b1);
    probe_exp("up_below", 650, 192, 1'b0);

    do_reset();
    do_ticks(B_LT, 200);
    probe_exp("lt_edge", 320, 200, 1'b1);
    probe_exp("lt_out", 319, 200, 1'b0);
    probe_exp("lt_right", 351, 200, 1'b1);
    probe_exp("lt_rout", 352, 200, 1'b0);

    do_reset();
    do_ticks(B_UP | B_DN | B_RT, 1);
    probe_exp("multi_tl", 640, 190, 1'b1);
    probe_exp("multi_above", 640, 189, 1'b0);
    probe_exp("multi_left", 639, 190, 1'b0);
    probe_exp("multi_br", 671, 221, 1'b1);
    probe_exp("multi_below", 640, 222, 1'b0);

    do_reset();
    do_ticks(B_RT, 10);
    probe_exp("pre_rst", 690, 200, 1'b1);
    @(negedge clk);
    curr_x = 11'd300; curr_y = 10'd100;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    mx = 640; my = 192;
    probe_exp("mid_rst_tl", 640, 192, 1'b1);
    probe_exp("mid_rst_l", 639, 192, 1'b0);
    probe_exp("mid_rst_r", 672, 192, 1'b0);
    do_ticks(B_RT, 1);
    probe_exp("post_rst_642", 642, 192, 1'b1);
    probe_exp("post_rst_641", 641, 192, 1'b0);

    // Open board: drive into every screen edge.
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        set_tile(r, c, $urandom_range(1, 21));
    do_reset();
    do_ticks(B_RT, 320);
    probe_exp("edge_r_in", 1279, 192, 1'b1);
    probe_exp("edge_r_tl", 1248, 192, 1'b1);
    probe_exp("edge_r_out", 1247, 192, 1'b0);
    probe_box("edge_r");
    do_ticks(B_DN, 300);
    probe_exp("edge_d_in", 1260, 799, 1'b1);
    probe_exp("edge_d_out", 1260, 767, 1'b0);
    probe_box("edge_d");
    do_ticks(B_LT, 640);
    probe_box("edge_l");
    do_ticks(B_UP, 400);
    probe_exp("edge_u_00", 0, 0, 1'b1);
    probe_exp("edge_u_31", 31, 31, 1'b1);
    probe_exp("edge_u_32", 32, 31, 1'b0);
    probe_box("edge_u");

    // Random grass layout with random button combinations.
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        set_tile(r, c, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 21));
    do_reset();
    for (int k = 0; k < 120; k++) begin
      do_ticks(4'($urandom_range(0, 15)), $urandom_range(1, 6));
      probe_box("rnd");
      probe("rnd_pix", $urandom_range(0, 1279), $urandom_range(0, 799));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
